ch_mem_ring_ctrl: RTL and testbench

//  Multi-lane channel-message ring memory with load handshake, rotation position tracking and write-back.

---
 rtl/ch_mem_pkg.sv | 30 +++
 rtl/ch_mem_lane_ring.sv | 37 +++
 rtl/ch_mem_ring_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ch_mem_ring_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ch_mem_pkg.sv
// Shared types and helpers for the channel-message ring memory: state encoding, sizing, lane slicing.
`ifndef CH_MEM_PKG_SV
`define CH_MEM_PKG_SV

// Lane l of a packed multi-lane bus whose lanes are w bits wide.
`define CH_MEM_LANE(bus, l, w) bus[(l)*(w) +: (w)]

package ch_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CIRC = 2'd2
    } ch_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int ch_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    function automatic int ch_depth(input int row_chunk_num, input int layer_num);
        return row_chunk_num * layer_num;
    endfunction

endpackage

`endif

// File: rtl/ch_mem_lane_ring.sv
// One lane's DEPTH-entry ring: indexed load, write-back into the head entry, head read out.
// Latency: writes land on the next edge; head read is combinational (0 cycles).
// Backpressure: none; write enables arrive pre-qualified from the controller.
module ch_mem_lane_ring
    import ch_mem_pkg::*;
#(
    parameter int QUAN_SIZE = 4,
    parameter int DEPTH     = 27,
    parameter int IDX_W     = ch_clog2(DEPTH)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 ld_en,
    input  logic [IDX_W-1:0]     ld_idx,
    input  logic [QUAN_SIZE-1:0] ld_dat,
    input  logic                 wb_en,
    input  logic [IDX_W-1:0]     head_idx,
    input  logic [QUAN_SIZE-1:0] wb_dat,
    output logic [QUAN_SIZE-1:0] head_dat
);

    logic [QUAN_SIZE-1:0] mem [DEPTH];

    // Rotation is a moving head pointer, so write-back targets the departing head entry.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_idx] <= ld_dat;
        end else if (wb_en) begin
            mem[head_idx] <= wb_dat;
        end
    end

    assign head_dat = mem[head_idx];

endmodule

// File: rtl/ch_mem_ring_ctrl.sv
// Multi-lane channel LLR ring: loads one frame, then circulates it to the layered decoder with position tags.
// Latency: head entry is 0-cycle from storage, +1 cycle on all CIRC outputs when CH_MEM_OUT_REG_EN is defined.
// Backpressure: load_ready is high only while loading; rotation advances only on rot_en.
module ch_mem_ring_ctrl
    import ch_mem_pkg::*;
#(
    parameter  int QUAN_SIZE     = 4,
    parameter  int LANES         = 85,
    parameter  int ROW_CHUNK_NUM = 9,
    parameter  int LAYER_NUM     = 3,
    localparam int DEPTH         = ch_depth(ROW_CHUNK_NUM, LAYER_NUM),
    localparam int IDX_W         = ch_clog2(DEPTH),
    localparam int CHUNK_W       = ch_clog2(ROW_CHUNK_NUM),
    localparam int LAYER_W       = ch_clog2(LAYER_NUM),
    localparam int BUS_W         = LANES * QUAN_SIZE
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [BUS_W-1:0]   load_data,
    input  logic               rot_en,
    input  logic               wb_en,
    input  logic [BUS_W-1:0]   wb_data,
    output logic [BUS_W-1:0]   ch_msg_out,
    output logic               out_valid,
    output logic [CHUNK_W-1:0] chunk_idx,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               rot_wrap,
    output logic               load_done
);

    ch_state_e          state;
    logic [IDX_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   head;
    logic [CHUNK_W-1:0] chunk_c;
    logic [LAYER_W-1:0] layer_c;
    logic               circ_vld;
    logic               wrap_c;

    logic               load_acc;
    logic               rot_go;
    logic               wb_go;
    logic               last_beat;
    logic               head_last;
    logic               chunk_last;
    logic               layer_last;
    logic [BUS_W-1:0]   head_bus;
    logic [BUS_W-1:0]   msg_c;
    logic [CHUNK_W-1:0] chunk_o;
    logic [LAYER_W-1:0] layer_o;

    // frame_start takes priority over both a load beat and a rotation step.
    assign load_acc   = (state == ST_LOAD) && load_valid && !frame_start;
    assign rot_go     = (state == ST_CIRC) && rot_en && !frame_start;
    assign wb_go      = rot_go && wb_en;
    assign last_beat  = (beat_cnt == IDX_W'(DEPTH - 1));
    assign head_last  = (head == IDX_W'(DEPTH - 1));
    assign chunk_last = (chunk_c == CHUNK_W'(ROW_CHUNK_NUM - 1));
    assign layer_last = (layer_c == LAYER_W'(LAYER_NUM - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            head       <= '0;
            chunk_c    <= '0;
            layer_c    <= '0;
            load_ready <= 1'b0;
            circ_vld   <= 1'b0;
            wrap_c     <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            wrap_c    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state      <= ST_LOAD;
                        load_ready <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (frame_start) begin
                        beat_cnt <= '0;
                    end else if (load_valid) begin
                        if (last_beat) begin
                            state      <= ST_CIRC;
                            load_ready <= 1'b0;
                            circ_vld   <= 1'b1;
                            load_done  <= 1'b1;
                            beat_cnt   <= '0;
                            head       <= '0;
                            chunk_c    <= '0;
                            layer_c    <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_CIRC: begin
                    if (frame_start) begin
                        state      <= ST_LOAD;
                        load_ready <= 1'b1;
                        circ_vld   <= 1'b0;
                        beat_cnt   <= '0;
                    end else if (rot_en) begin
                        wrap_c <= head_last;
                        head   <= head_last ? '0 : head + 1'b1;
                        // Chunk counter carries into the layer counter instead of dividing pos.
                        if (chunk_last) begin
                            chunk_c <= '0;
                            layer_c <= layer_last ? '0 : layer_c + 1'b1;
                        end else begin
                            chunk_c <= chunk_c + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b0;
                    circ_vld   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ch_mem_lane_ring #(
            .QUAN_SIZE (QUAN_SIZE),
            .DEPTH     (DEPTH),
            .IDX_W     (IDX_W)
        ) u_ring (
            .sys_clk  (sys_clk),
            .rst      (rst),
            .ld_en    (load_acc),
            .ld_idx   (beat_cnt),
            .ld_dat   (`CH_MEM_LANE(load_data, l, QUAN_SIZE)),
            .wb_en    (wb_go),
            .head_idx (head),
            .wb_dat   (`CH_MEM_LANE(wb_data, l, QUAN_SIZE)),
            .head_dat (`CH_MEM_LANE(head_bus, l, QUAN_SIZE))
        );
    end

    assign msg_c   = circ_vld ? head_bus : '0;
    assign chunk_o = circ_vld ? chunk_c  : '0;
    assign layer_o = circ_vld ? layer_c  : '0;

`ifdef CH_MEM_OUT_REG_EN
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ch_msg_out <= '0;
            out_valid  <= 1'b0;
            chunk_idx  <= '0;
            layer_idx  <= '0;
            rot_wrap   <= 1'b0;
        end else begin
            ch_msg_out <= msg_c;
            out_valid  <= circ_vld;
            chunk_idx  <= chunk_o;
            layer_idx  <= layer_o;
            rot_wrap   <= wrap_c;
        end
    end
`else
    assign ch_msg_out = msg_c;
    assign out_valid  = circ_vld;
    assign chunk_idx  = chunk_o;
    assign layer_idx  = layer_o;
    assign rot_wrap   = wrap_c;
`endif

endmodule

// File: tb/tb_ch_mem_ring_ctrl.sv
// Directed bench for ch_mem_ring_ctrl on a 2-lane, 3x2 ring; follows CH_MEM_OUT_REG_EN for output latency.
module tb_ch_mem_ring_ctrl;

    localparam int QS = 4;
    localparam int LN = 2;
    localparam int RC = 3;
    localparam int LY = 2;
    localparam int D  = RC * LY;
    localparam int BW = LN * QS;
`ifdef CH_MEM_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          sys_clk     = 1'b0;
    logic          rst         = 1'b1;
    logic          frame_start = 1'b0;
    logic          load_valid  = 1'b0;
    logic          rot_en      = 1'b0;
    logic          wb_en       = 1'b0;
    logic [BW-1:0] load_data   = '0;
    logic [BW-1:0] wb_data     = '0;
    logic          load_ready;
    logic          out_valid;
    logic          rot_wrap;
    logic          load_done;
    logic [BW-1:0] ch_msg_out;
    logic [1:0]    chunk_idx;
    logic [0:0]    layer_idx;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [3:0] ref0 [D];
    logic [3:0] ref1 [D];
    int         pos   = 0;

    ch_mem_ring_ctrl #(
        .QUAN_SIZE     (QS),
        .LANES         (LN),
        .ROW_CHUNK_NUM (RC),
        .LAYER_NUM     (LY)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .frame_start (frame_start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .rot_en      (rot_en),
        .wb_en       (wb_en),
        .wb_data     (wb_data),
        .ch_msg_out  (ch_msg_out),
        .out_valid   (out_valid),
        .chunk_idx   (chunk_idx),
        .layer_idx   (layer_idx),
        .rot_wrap    (rot_wrap),
        .load_done   (load_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},   32'(load_ready), 0);
        check({tag, "_vld"},   32'(out_valid),  0);
        check({tag, "_out"},   32'(ch_msg_out), 0);
        check({tag, "_chunk"}, 32'(chunk_idx),  0);
        check({tag, "_layer"}, 32'(layer_idx),  0);
        check({tag, "_wrap"},  32'(rot_wrap),   0);
        check({tag, "_done"},  32'(load_done),  0);
    endtask

    // Called just after a negedge. Loads lane0 = b0.., lane1 = b1.., optionally with valid gaps,
    // a frame_start restart after restart_at beats, and rot_en/wb_en held high throughout.
    task automatic load_frame(input logic [3:0] b0, input logic [3:0] b1, input bit toggle,
                              input int restart_at, input bit rot_hold);
        int         k;
        int         guard;
        bit         restarted;
        logic [3:0] l0;
        logic [3:0] l1;
        k = 0; guard = 0; restarted = 1'b0;
        frame_start = 1'b1; rot_en = rot_hold; wb_en = rot_hold; wb_data = 8'hFF;
        @(negedge sys_clk);
        frame_start = 1'b0;
        check("ld_rdy", 32'(load_ready), 1);
        repeat (LAT) @(negedge sys_clk);
        check("ld_ovld", 32'(out_valid), 0);
        check("ld_out", 32'(ch_msg_out), 0);
        while (k < D && guard < 40) begin
            guard++;
            check("ld_early", 32'(load_done), 0);
            if (toggle && (guard % 2 == 0)) begin
                load_valid = 1'b0; load_data = 8'hEE;
            end else if (!restarted && k == restart_at) begin
                frame_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
                restarted = 1'b1; k = 0;
            end else begin
                l0 = b0 + 4'(k); l1 = b1 + 4'(k);
                load_valid = 1'b1; load_data = {l1, l0};
                ref0[k] = l0; ref1[k] = l1;
                k++;
            end
            @(negedge sys_clk);
            frame_start = 1'b0;
        end
        load_valid = 1'b0; rot_en = 1'b0; wb_en = 1'b0;
        check("ld_done", 32'(load_done), 1);
        check("ld_rdy_off", 32'(load_ready), 0);
        @(negedge sys_clk);
        check("ld_done_pulse", 32'(load_done), 0);
        check("ld_ovld_on", 32'(out_valid), 1);
        pos = 0;
    endtask

    // Called just after a negedge with outputs showing pos. Steps n times; the first step may write back.
    task automatic rotate(input int n, input bit wb, input logic [7:0] wbv);
        int p0;
        int p;
        p0 = pos;
        check("head", 32'(ch_msg_out), {24'd0, ref1[p0], ref0[p0]});
        check("head_chunk", 32'(chunk_idx), p0 % RC);
        check("head_layer", 32'(layer_idx), p0 / RC);
        rot_en = (n > 0); wb_en = wb; wb_data = wbv;
        if (wb) begin
            ref0[p0] = wbv[3:0];
            ref1[p0] = wbv[7:4];
        end
        for (int j = 1; j <= n + LAT; j++) begin
            @(negedge sys_clk);
            rot_en = (j < n); wb_en = 1'b0;
            if (j - LAT >= 1) begin
                p = (p0 + j - LAT) % D;
                check("rot_out", 32'(ch_msg_out), {24'd0, ref1[p], ref0[p]});
                check("rot_chunk", 32'(chunk_idx), p % RC);
                check("rot_layer", 32'(layer_idx), p / RC);
                check("rot_wrap", 32'(rot_wrap), 32'(p == 0));
                check("rot_vld", 32'(out_valid), 1);
            end
        end
        pos = (p0 + n) % D;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        @(negedge sys_clk);
        check_all_zero("rst");
        rst = 1'b0;
        @(negedge sys_clk);

        // IDLE ignores beats and rotation.
        load_valid = 1'b1; load_data = 8'h55; rot_en = 1'b1;
        @(negedge sys_clk);
        check("idle_rdy", 32'(load_ready), 0);
        check("idle_vld", 32'(out_valid), 0);
        load_valid = 1'b0; rot_en = 1'b0;

        // Plain load, full rotation, write-back of lane0=15 / lane1=3 at entry 0.
        load_frame(4'd1, 4'd9, 1'b0, -1, 1'b0);
        check("t1_out", 32'(ch_msg_out), 32'h91);
        check("t1_chunk", 32'(chunk_idx), 0);
        check("t1_layer", 32'(layer_idx), 0);
        rotate(6, 1'b0, 8'h00);
        rotate(7, 1'b1, 8'h3F);
        rotate(3, 1'b0, 8'h00);
        check("t5_out", 32'(ch_msg_out), 32'hD5);
        check("t5_chunk", 32'(chunk_idx), 1);
        check("t5_layer", 32'(layer_idx), 1);

        // frame_start at pos 4 with rot_en, rot_en held during reload.
        load_frame(4'd7, 4'd0, 1'b0, -1, 1'b1);
        check("t5_reload", 32'(ch_msg_out), 32'h07);
        rotate(6, 1'b0, 8'h00);

        // Gapped valid plus a restart after two beats.
        load_frame(4'd2, 4'd4, 1'b1, 2, 1'b1);
        check("t4_out", 32'(ch_msg_out), 32'h42);
        rotate(6, 1'b0, 8'h00);

        // Asynchronous reset between edges in the middle of a load.
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0; load_valid = 1'b1; load_data = 8'h77;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("pre_rst_rdy", 32'(load_ready), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("arst");
        load_valid = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_rdy", 32'(load_ready), 0);
        check("post_rst_vld", 32'(out_valid), 0);

        load_frame(4'd3, 4'd5, 1'b0, -1, 1'b0);
        check("final_out", 32'(ch_msg_out), 32'h53);
        rotate(6, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
